// File: rtl/timer_set_ctrl.sv
// timer_set_ctrl: key-driven min:sec preset entry, run/abort control for the
// countdown timer core, and a timed alarm with a square-wave beeper.
module timer_set_ctrl #(
  parameter int MIN_MAX      = 7,
  parameter int SEC_MAX      = 59,
  parameter int ALARM_CYCLES = 1000,
  parameter int BEEP_DIV     = 50
) (
  input  logic       SYSCLK,
  input  logic       RST,
  input  logic       KEY_MIN,
  input  logic       KEY_SEC,
  input  logic       KEY_CLR,
  input  logic       KEY_START,
  input  logic       TIME_UP,
  output logic [2:0] TIME_MIN,
  output logic [5:0] TIME_SEC,
  output logic       START,
  output logic       ALARM,
  output logic       BEEP
);

  localparam int ACW = $clog2(ALARM_CYCLES + 1);
  localparam int BCW = $clog2(BEEP_DIV + 1);

  localparam logic [2:0]     MIN_LAST   = 3'(MIN_MAX);
  localparam logic [5:0]     SEC_LAST   = 6'(SEC_MAX);
  localparam logic [ACW-1:0] ALARM_LAST = ACW'(ALARM_CYCLES - 1);
  localparam logic [BCW-1:0] BEEP_LAST  = BCW'(BEEP_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_ALARM = 2'd2
  } state_t;

  // Key vector order: {START, CLR, SEC, MIN}
  logic [3:0]     keys;
  logic [3:0]     key_q, key_d;
  logic [3:0]     key_edge;
  logic           edge_min, edge_sec, edge_clr, edge_start;

  state_t         state_q, state_d;
  logic [2:0]     time_min_q, time_min_d;
  logic [5:0]     time_sec_q, time_sec_d;
  logic           start_q, start_d;
  logic           alarm_q, alarm_d;
  logic           beep_q, beep_d;
  logic [ACW-1:0] alarm_cnt_q, alarm_cnt_d;
  logic [BCW-1:0] beep_cnt_q, beep_cnt_d;

  assign keys       = {KEY_START, KEY_CLR, KEY_SEC, KEY_MIN};
  assign key_edge   = keys & ~key_q;
  assign edge_min   = key_edge[0];
  assign edge_sec   = key_edge[1];
  assign edge_clr   = key_edge[2];
  assign edge_start = key_edge[3];

  // Next-state and next-output logic; every output is a flop so it changes
  // one cycle after the key edge that caused it.
  always_comb begin
    key_d       = keys;
    state_d     = state_q;
    time_min_d  = time_min_q;
    time_sec_d  = time_sec_q;
    start_d     = start_q;
    alarm_d     = alarm_q;
    beep_d      = beep_q;
    alarm_cnt_d = alarm_cnt_q;
    beep_cnt_d  = beep_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (edge_clr) begin
          time_min_d = 3'd0;
          time_sec_d = 6'd0;
        end else if (edge_start) begin
          // A 0:00 preset would expire immediately, so it is not started.
          if ((time_min_q != 3'd0) || (time_sec_q != 6'd0)) begin
            state_d = S_RUN;
            start_d = 1'b1;
          end
        end else begin
          // Minute and second fields wrap independently; no carry.
          if (edge_min) begin
            time_min_d = (time_min_q == MIN_LAST) ? 3'd0 : time_min_q + 3'd1;
          end
          if (edge_sec) begin
            time_sec_d = (time_sec_q == SEC_LAST) ? 6'd0 : time_sec_q + 6'd1;
          end
        end
      end

      S_RUN: begin
        // Abort outranks a simultaneous TIME_UP.
        if (edge_start) begin
          state_d = S_IDLE;
          start_d = 1'b0;
        end else if (TIME_UP) begin
          state_d     = S_ALARM;
          start_d     = 1'b0;
          alarm_d     = 1'b1;
          beep_d      = 1'b0;
          alarm_cnt_d = '0;
          beep_cnt_d  = '0;
        end
      end

      S_ALARM: begin
        // Any key acknowledges; the key's own action is swallowed.
        if ((|key_edge) || (alarm_cnt_q == ALARM_LAST)) begin
          state_d     = S_IDLE;
          alarm_d     = 1'b0;
          beep_d      = 1'b0;
          alarm_cnt_d = '0;
          beep_cnt_d  = '0;
        end else begin
          alarm_cnt_d = alarm_cnt_q + 1'b1;
          if (beep_cnt_q == BEEP_LAST) begin
            beep_cnt_d = '0;
            beep_d     = ~beep_q;
          end else begin
            beep_cnt_d = beep_cnt_q + 1'b1;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
        start_d = 1'b0;
        alarm_d = 1'b0;
        beep_d  = 1'b0;
      end
    endcase
  end

  // State register; key history resets high so a key held through reset
  // must be released before it can act.
  always_ff @(posedge SYSCLK) begin
    if (RST) begin
      key_q       <= 4'b1111;
      state_q     <= S_IDLE;
      time_min_q  <= 3'd0;
      time_sec_q  <= 6'd0;
      start_q     <= 1'b0;
      alarm_q     <= 1'b0;
      beep_q      <= 1'b0;
      alarm_cnt_q <= '0;
      beep_cnt_q  <= '0;
    end else begin
      key_q       <= key_d;
      state_q     <= state_d;
      time_min_q  <= time_min_d;
      time_sec_q  <= time_sec_d;
      start_q     <= start_d;
      alarm_q     <= alarm_d;
      beep_q      <= beep_d;
      alarm_cnt_q <= alarm_cnt_d;
      beep_cnt_q  <= beep_cnt_d;
    end
  end

  assign TIME_MIN = time_min_q;
  assign TIME_SEC = time_sec_q;
  assign START    = start_q;
  assign ALARM    = alarm_q;
  assign BEEP     = beep_q;

endmodule
